// File: rtl/data_memory_lsu.sv
// data_memory_lsu: byte-addressed RV32 data RAM with B/H/W loads/stores, req/ready in, one-cycle rvalid/err out.
// Define DATA_MEMORY_LSU_SPLIT_EN to split word-crossing accesses over two cycles; otherwise misaligned accesses error.
module data_memory_lsu #(
  parameter int DEPTH_WORDS = 64,
  parameter int ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              we,
  input  logic [1:0]        size,
  input  logic              unsigned_ld,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              ready,
  output logic              rvalid,
  output logic [31:0]       rdata,
  output logic              err
);
  localparam int AW = $clog2(DEPTH_WORDS);

`ifdef DATA_MEMORY_LSU_SPLIT_EN
  typedef enum logic [1:0] {S_IDLE, S_RESP, S_SPLIT} state_t;
`else
  typedef enum logic {S_IDLE, S_RESP} state_t;
`endif

  logic [31:0]       r_mem [DEPTH_WORDS];
  state_t            r_state;
  logic              r_rvalid;
  logic              r_err;
  logic [31:0]       r_rdata;

  logic [1:0]        w_off;
  logic [AW-1:0]     w_idx;
  logic              w_accept;
  logic [1:0]        w_nm1;
  logic [3:0]        w_base;
  logic [ADDR_W:0]   w_last;
  logic              w_oor;
  logic              w_bad;
  logic [1:0]        w_ext_off;
  logic [1:0]        w_ext_size;
  logic              w_ext_uns;
  logic [31:0]       w_sh;
  logic [31:0]       w_ld;
  logic              w_wr_en;
  logic [AW-1:0]     w_wr_idx;
  logic [3:0]        w_wr_be;
  logic [31:0]       w_wr_dat;

`ifdef DATA_MEMORY_LSU_SPLIT_EN
  logic              r_ready;
  logic              r_we;
  logic [1:0]        r_off;
  logic [1:0]        r_size;
  logic              r_uns;
  logic [AW-1:0]     r_idx_hi;
  logic [3:0]        r_be_hi;
  logic [31:0]       r_wd_hi;
  logic [31:0]       r_lo;
  logic              w_cross;
  logic [7:0]        w_be;
  logic [63:0]       w_wd;
  logic [55:0]       w_span;

  assign ready = r_ready;
`else
  logic              w_misal;
  logic [3:0]        w_be;
  logic [31:0]       w_wd;

  assign ready = 1'b1;
`endif

  assign w_off    = addr[1:0];
  assign w_idx    = addr[AW+1:2];
  assign w_accept = req && ready;
  assign rvalid   = r_rvalid;
  assign rdata    = r_rdata;
  assign err      = r_err;

  // Range check uses the last byte touched, with a carry bit so address wrap counts as out of range.
  always_comb begin
    case (size)
      2'b00:   begin w_nm1 = 2'd0; w_base = 4'b0001; end
      2'b01:   begin w_nm1 = 2'd1; w_base = 4'b0011; end
      default: begin w_nm1 = 2'd3; w_base = 4'b1111; end
    endcase
    w_last = {1'b0, addr} + {{(ADDR_W-1){1'b0}}, w_nm1};
    w_oor  = |w_last[ADDR_W:AW+2];
`ifdef DATA_MEMORY_LSU_SPLIT_EN
    w_cross = (size == 2'b01 && w_off == 2'd3) || (size == 2'b10 && w_off != 2'd0);
    w_bad   = (size == 2'b11) || w_oor;
    w_be    = {4'b0000, w_base} << w_off;
    w_wd    = {32'h0, wdata} << {w_off, 3'b000};
`else
    w_misal = (size == 2'b01 && w_off[0]) || (size == 2'b10 && w_off != 2'd0);
    w_bad   = (size == 2'b11) || w_oor || w_misal;
    w_be    = w_base << w_off;
    w_wd    = wdata << {w_off, 3'b000};
`endif
  end

  // Load alignment: in SPLIT the second word supplies the upper bytes of the span.
`ifdef DATA_MEMORY_LSU_SPLIT_EN
  always_comb begin
    if (r_state == S_SPLIT) begin
      w_span     = {r_mem[r_idx_hi][23:0], r_lo};
      w_ext_off  = r_off;
      w_ext_size = r_size;
      w_ext_uns  = r_uns;
    end else begin
      w_span     = {24'h0, r_mem[w_idx]};
      w_ext_off  = w_off;
      w_ext_size = size;
      w_ext_uns  = unsigned_ld;
    end
    w_sh = w_span[{w_ext_off, 3'b000} +: 32];
  end
`else
  assign w_ext_off  = w_off;
  assign w_ext_size = size;
  assign w_ext_uns  = unsigned_ld;
  assign w_sh       = r_mem[w_idx] >> {w_ext_off, 3'b000};
`endif

  always_comb begin
    case (w_ext_size)
      2'b00:   w_ld = {{24{~w_ext_uns & w_sh[7]}}, w_sh[7:0]};
      2'b01:   w_ld = {{16{~w_ext_uns & w_sh[15]}}, w_sh[15:0]};
      default: w_ld = w_sh;
    endcase
  end

  always_comb begin
    w_wr_en  = w_accept && we && !w_bad;
    w_wr_idx = w_idx;
    w_wr_be  = w_be[3:0];
    w_wr_dat = w_wd[31:0];
`ifdef DATA_MEMORY_LSU_SPLIT_EN
    if (r_state == S_SPLIT && r_we) begin
      w_wr_en  = 1'b1;
      w_wr_idx = r_idx_hi;
      w_wr_be  = r_be_hi;
      w_wr_dat = r_wd_hi;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (w_wr_be[b]) r_mem[w_wr_idx][8*b +: 8] <= w_wr_dat[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_rvalid <= 1'b0;
      r_err    <= 1'b0;
      r_rdata  <= '0;
`ifdef DATA_MEMORY_LSU_SPLIT_EN
      r_ready  <= 1'b1;
      r_we     <= 1'b0;
      r_off    <= '0;
      r_size   <= '0;
      r_uns    <= 1'b0;
      r_idx_hi <= '0;
      r_be_hi  <= '0;
      r_wd_hi  <= '0;
      r_lo     <= '0;
`endif
    end else begin
      case (r_state)
`ifdef DATA_MEMORY_LSU_SPLIT_EN
        S_SPLIT: begin
          r_state  <= S_RESP;
          r_ready  <= 1'b1;
          r_rvalid <= 1'b1;
          r_err    <= 1'b0;
          r_rdata  <= r_we ? '0 : w_ld;
        end
`endif
        default: begin
          if (!w_accept) begin
            r_state  <= S_IDLE;
            r_rvalid <= 1'b0;
            r_err    <= 1'b0;
            r_rdata  <= '0;
`ifdef DATA_MEMORY_LSU_SPLIT_EN
          end else if (w_cross && !w_bad) begin
            r_state  <= S_SPLIT;
            r_ready  <= 1'b0;
            r_rvalid <= 1'b0;
            r_err    <= 1'b0;
            r_rdata  <= '0;
            r_we     <= we;
            r_off    <= w_off;
            r_size   <= size;
            r_uns    <= unsigned_ld;
            r_idx_hi <= w_idx + 1'b1;
            r_be_hi  <= w_be[7:4];
            r_wd_hi  <= w_wd[63:32];
            r_lo     <= r_mem[w_idx];
`endif
          end else begin
            r_state  <= S_RESP;
            r_rvalid <= 1'b1;
            r_err    <= w_bad;
            r_rdata  <= (w_bad || we) ? '0 : w_ld;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_memory_lsu.sv
// Self-checking bench for data_memory_lsu: byte-level reference model feeding an expected-response queue.
module tb_data_memory_lsu;
  typedef struct packed {
    logic        w;
    logic [1:0]  sz;
    logic        u;
    logic [31:0] a;
    logic [31:0] d;
  } acc_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [1:0]  size = 2'b00;
  logic        unsigned_ld = 1'b0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic        ready;
  logic        rvalid;
  logic [31:0] rdata;
  logic        err;

  int          checks = 0;
  int          passed = 0;
  logic [32:0] exp_q[$];
  logic [7:0]  m_mem [256];

  data_memory_lsu #(.DEPTH_WORDS(64), .ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .size(size),
    .unsigned_ld(unsigned_ld), .addr(addr), .wdata(wdata),
    .ready(ready), .rvalid(rvalid), .rdata(rdata), .err(err)
  );

  always #5 clk = ~clk;

  // Reference model: returns {err, rdata} and applies stores to the byte array.
  function automatic logic [32:0] model(input acc_t x);
    int nb;
    logic bad;
    logic [31:0] v;
    nb  = (x.sz == 2'd0) ? 1 : (x.sz == 2'd1) ? 2 : 4;
    bad = (x.sz == 2'd3) || (x.a > 32'(256 - nb));
`ifndef DATA_MEMORY_LSU_SPLIT_EN
    if ((x.sz == 2'd1 && x.a[0]) || (x.sz == 2'd2 && x.a[1:0] != 2'd0)) bad = 1'b1;
`endif
    if (bad) return {1'b1, 32'h0};
    if (x.w) begin
      for (int i = 0; i < nb; i++) m_mem[x.a + 32'(i)] = x.d[8*i +: 8];
      return {1'b0, 32'h0};
    end
    v = 32'h0;
    for (int i = 0; i < nb; i++) v[8*i +: 8] = m_mem[x.a + 32'(i)];
    if (!x.u && nb == 1) v = {{24{v[7]}}, v[7:0]};
    if (!x.u && nb == 2) v = {{16{v[15]}}, v[15:0]};
    return {1'b0, v};
  endfunction

  // Drive at negedge, hold until ready, push expected, return at the accepting edge (req left high).
  task automatic issue(input acc_t x);
    int t;
    @(negedge clk);
    req = 1'b1; we = x.w; size = x.sz; unsigned_ld = x.u; addr = x.a; wdata = x.d;
    t = 0;
    while (!ready && t < 10) begin @(negedge clk); t++; end
    if (!ready) begin
      checks++;
      $display("FAIL accept_timeout: ready=%b after %0d cycles, want 1", ready, t);
    end
    exp_q.push_back(model(x));
    @(posedge clk);
  endtask

  task automatic issue_one(input acc_t x);
    issue(x);
    @(negedge clk);
    req = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", ready); else passed++;
    checks++; if (rvalid !== 1'b0) $display("FAIL reset_rvalid: got %b want 0", rvalid); else passed++;
    checks++; if (rdata !== 32'h0) $display("FAIL reset_rdata: got %h want 0", rdata); else passed++;
    checks++; if (err !== 1'b0) $display("FAIL reset_err: got %b want 0", err); else passed++;
    rst_n = 1'b1;
  endtask

  // Fills every word back-to-back, then reads some back; responses must arrive on consecutive cycles.
  task automatic test_back_to_back();
    fork
      begin
        for (int i = 0; i < 64; i++) issue('{1'b1, 2'd2, 1'b0, 32'(i * 4), 32'h9E3779B9 * 32'(i + 1)});
        for (int i = 0; i < 8; i++) issue('{1'b0, 2'd2, 1'b0, 32'(i * 20), 32'h0});
        @(negedge clk);
        req = 1'b0;
      end
      begin
        for (int k = 0; k < 72; k++) begin
          int t;
          logic [32:0] e;
          t = 0;
          do begin @(negedge clk); t++; end while (!rvalid && t < 20);
          checks++;
          if (!rvalid || exp_q.size() == 0) begin
            $display("FAIL b2b_timeout[%0d]: rvalid=%b queued=%0d, want a response", k, rvalid, exp_q.size());
          end else begin
            e = exp_q.pop_front();
            if ({err, rdata} !== e || (k > 0 && t != 1))
              $display("FAIL b2b[%0d]: got err=%b rdata=%h gap=%0d, want err=%b rdata=%h gap=1",
                       k, err, rdata, t, e[32], e[31:0]);
            else passed++;
          end
        end
      end
    join
  endtask

  task automatic test_word();
    logic [32:0] e;
    issue_one('{1'b1, 2'd2, 1'b0, 32'h4, 32'h0000000A});
    checks++; e = exp_q.pop_front();
    if (rvalid !== 1'b1 || {err, rdata} !== e)
      $display("FAIL sw_resp: got rvalid=%b err=%b rdata=%h, want 1 %b %h", rvalid, err, rdata, e[32], e[31:0]);
    else passed++;
    @(negedge clk);
    checks++; if (rvalid !== 1'b0) $display("FAIL rvalid_pulse: got %b want 0", rvalid); else passed++;
    issue_one('{1'b0, 2'd2, 1'b0, 32'h4, 32'h0});
    checks++; e = exp_q.pop_front();
    if (rvalid !== 1'b1 || err !== 1'b0 || rdata !== 32'h0000000A || {err, rdata} !== e)
      $display("FAIL lw_resp: got rvalid=%b err=%b rdata=%h, want 1 0 0000000a", rvalid, err, rdata);
    else passed++;
  endtask

  task automatic run_table(input string name, input acc_t s[$]);
    foreach (s[i]) begin
      logic [32:0] e;
      issue_one(s[i]);
      checks++; e = exp_q.pop_front();
      if (rvalid !== 1'b1 || {err, rdata} !== e)
        $display("FAIL %s[%0d]: got rvalid=%b err=%b rdata=%h, want 1 %b %h",
                 name, i, rvalid, err, rdata, e[32], e[31:0]);
      else passed++;
    end
  endtask

  task automatic test_byte_half();
    acc_t s[$];
    s = '{'{1'b1, 2'd2, 1'b0, 32'h60, 32'h00000007}, '{1'b1, 2'd0, 1'b0, 32'h61, 32'h00000080},
          '{1'b0, 2'd2, 1'b0, 32'h60, 32'h0},        '{1'b0, 2'd0, 1'b0, 32'h61, 32'h0},
          '{1'b0, 2'd0, 1'b1, 32'h61, 32'h0},        '{1'b0, 2'd1, 1'b0, 32'h60, 32'h0},
          '{1'b0, 2'd1, 1'b1, 32'h60, 32'h0},        '{1'b1, 2'd1, 1'b0, 32'h62, 32'h1234ABCD},
          '{1'b0, 2'd2, 1'b0, 32'h60, 32'h0}};
    run_table("byte_half", s);
  endtask

  task automatic test_errors();
    acc_t s[$];
    s = '{'{1'b1, 2'd2, 1'b0, 32'hFC, 32'hCAFEBABE}, '{1'b1, 2'd2, 1'b0, 32'hFE, 32'hDEADBEEF},
          '{1'b0, 2'd2, 1'b0, 32'hFC, 32'h0},        '{1'b0, 2'd3, 1'b0, 32'h10, 32'h0},
          '{1'b1, 2'd3, 1'b0, 32'h10, 32'hFFFFFFFF}, '{1'b1, 2'd0, 1'b0, 32'h100, 32'h55},
          '{1'b0, 2'd0, 1'b1, 32'hFF, 32'h0},        '{1'b0, 2'd2, 1'b0, 32'h100, 32'h0},
          '{1'b0, 2'd1, 1'b0, 32'hFF, 32'h0},        '{1'b0, 2'd2, 1'b0, 32'h10, 32'h0}};
    run_table("errors", s);
  endtask

  task automatic test_misaligned();
    acc_t s[$];
    s = '{'{1'b1, 2'd2, 1'b0, 32'h0, 32'h01020304}, '{1'b1, 2'd2, 1'b0, 32'h4, 32'h05060708},
          '{1'b1, 2'd1, 1'b0, 32'h3, 32'h0000BEEF}, '{1'b0, 2'd2, 1'b0, 32'h0, 32'h0},
          '{1'b0, 2'd2, 1'b0, 32'h4, 32'h0},        '{1'b1, 2'd1, 1'b0, 32'h1, 32'h0000AAAA},
          '{1'b0, 2'd2, 1'b0, 32'h0, 32'h0},        '{1'b0, 2'd1, 1'b1, 32'h1, 32'h0},
          '{1'b0, 2'd2, 1'b0, 32'h6, 32'h0}};
    run_table("misaligned", s);
  endtask

`ifdef DATA_MEMORY_LSU_SPLIT_EN
  task automatic test_split();
    logic [32:0] e;
    acc_t s[$];
    s = '{'{1'b1, 2'd2, 1'b0, 32'h0C, 32'h0}, '{1'b1, 2'd2, 1'b0, 32'h10, 32'h0}};
    run_table("split_init", s);
    for (int j = 0; j < 2; j++) begin
      issue_one('{~j[0], 2'd2, 1'b0, 32'h0E, 32'h11223344});
      checks++;
      if (ready !== 1'b0 || rvalid !== 1'b0)
        $display("FAIL split_busy[%0d]: got ready=%b rvalid=%b, want 0 0", j, ready, rvalid);
      else passed++;
      @(negedge clk);
      checks++; e = exp_q.pop_front();
      if (rvalid !== 1'b1 || ready !== 1'b1 || {err, rdata} !== e)
        $display("FAIL split_resp[%0d]: got rvalid=%b ready=%b err=%b rdata=%h, want 1 1 %b %h",
                 j, rvalid, ready, err, rdata, e[32], e[31:0]);
      else passed++;
    end
    s = '{'{1'b0, 2'd2, 1'b0, 32'h0C, 32'h0}, '{1'b0, 2'd2, 1'b0, 32'h10, 32'h0}};
    run_table("split_words", s);
  endtask

  task automatic test_reset_split();
    logic [32:0] e;
    int seen;
    issue('{1'b0, 2'd2, 1'b0, 32'h0E, 32'h0});
    #2;
    req = 1'b0;
    rst_n = 1'b0;
    void'(exp_q.pop_back());
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (3) begin
      if (rvalid) seen++;
      @(negedge clk);
    end
    checks++; if (seen != 0) $display("FAIL rst_split_rvalid: got %0d pulses want 0", seen); else passed++;
    checks++; if (ready !== 1'b1) $display("FAIL rst_split_ready: got %b want 1", ready); else passed++;
    issue_one('{1'b0, 2'd2, 1'b0, 32'h10, 32'h0});
    checks++; e = exp_q.pop_front();
    if (rvalid !== 1'b1 || {err, rdata} !== e)
      $display("FAIL rst_split_next: got rvalid=%b err=%b rdata=%h, want 1 %b %h", rvalid, err, rdata, e[32], e[31:0]);
    else passed++;
  endtask
`endif

  task automatic test_random();
    fork
      begin
        for (int i = 0; i < 80; i++)
          issue('{1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  32'($urandom_range(0, 263)), $urandom()});
        @(negedge clk);
        req = 1'b0;
      end
      begin
        for (int k = 0; k < 80; k++) begin
          int t;
          logic [32:0] e;
          t = 0;
          do begin @(negedge clk); t++; end while (!rvalid && t < 20);
          checks++;
          if (!rvalid || exp_q.size() == 0) begin
            $display("FAIL rand_timeout[%0d]: rvalid=%b queued=%0d, want a response", k, rvalid, exp_q.size());
          end else begin
            e = exp_q.pop_front();
            if ({err, rdata} !== e)
              $display("FAIL rand[%0d]: got err=%b rdata=%h, want err=%b rdata=%h", k, err, rdata, e[32], e[31:0]);
            else passed++;
          end
        end
      end
    join
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at time %0t, want finished", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_back_to_back();
    test_word();
    test_byte_half();
    test_errors();
    test_misaligned();
`ifdef DATA_MEMORY_LSU_SPLIT_EN
    test_split();
    test_reset_split();
`endif
    test_random();
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
